// File: rtl/binary_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package binary_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count steps 0..w-1 (never less than one bit).
    function automatic int cnt_width(input int w);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_div_step.sv
// One combinational restoring-division stage: shift in a dividend bit, trial-subtract
// the divisor through a ripple chain of full-adder cells, restore on borrow.
module binary_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   c;

    assign shifted = {rem_in, bit_in};
    assign nb      = ~divisor;
    assign c[0]    = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign diff[i]  = shifted[i] ^ nb[i] ^ c[i];
        assign c[i + 1] = (shifted[i] & nb[i]) | (c[i] & (shifted[i] ^ nb[i]));
    end

    // Top cell subtracts an implicit zero (inverted to one): its carry-out is the
    // no-borrow flag, i.e. the trial result is non-negative.
    assign q_bit   = shifted[WIDTH] | c[WIDTH];
    assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/binary_div_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Define BINARY_DIV_SIGNED_EN for two's-complement operands (default: unsigned).
module binary_div_seq
    import binary_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // in_ready is high only in IDLE, out_valid only in DONE; the producer holds its
    // data stable while valid is high and not yet taken.

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, sh, dvs;
    logic [WIDTH-1:0] step_rem, q_final, a_abs, b_abs;
    logic             step_q, accept, last_step;

`ifdef BINARY_DIV_SIGNED_EN
    logic neg_q, neg_r;
    assign a_abs = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign b_abs = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
`else
    assign a_abs = dividend;
    assign b_abs = divisor;
`endif

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign q_final   = {sh[WIDTH-2:0], step_q};
    assign dbg_state = state;

    binary_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (sh[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = (divisor == '0) ? DONE : CALC;
            end
            CALC: begin
                if (last_step) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            sh          <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef BINARY_DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            cnt <= '0;
                            rem <= '0;
                            sh  <= a_abs;
                            dvs <= b_abs;
`ifdef BINARY_DIV_SIGNED_EN
                            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    sh  <= q_final;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
`ifdef BINARY_DIV_SIGNED_EN
                        // Truncation toward zero; remainder follows the dividend's sign.
                        quotient  <= neg_q ? (~q_final + WIDTH'(1)) : q_final;
                        remainder <= neg_r ? (~step_rem + WIDTH'(1)) : step_rem;
`else
                        quotient  <= q_final;
                        remainder <= step_rem;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_div_seq.sv
// Directed self-checking bench for binary_div_seq (WIDTH=8), unsigned or signed build.
module tb_binary_div_seq;
    import binary_div_pkg::*;

    localparam int W     = 8;
    localparam int LIMIT = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    binary_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // driver: present operands, wait for the result, hand it off
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("timeout", out_valid, 1);
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic ez, input int el);
        logic [W-1:0] q, r;
        logic z;
        int lat;
        exp_q.push_back(eq);
        exp_q.push_back(er);
        run_op(a, b, q, r, z, lat);
        chk({name, "_q"},   q,   exp_q.pop_front());
        chk({name, "_r"},   r,   exp_q.pop_front());
        chk({name, "_dbz"}, z,   ez);
        chk({name, "_lat"}, lat, el);
        chk({name, "_idle_rdy"}, in_ready, 1);
        chk({name, "_ov_clr"},   out_valid, 0);
        chk({name, "_dbz_clr"},  div_by_zero, 0);
    endtask

    initial begin
        logic [W-1:0] q, r, eq, er;
        logic z;
        int lat, seen, sa, sb;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q",         quotient, 0);
        chk("rst_r",         remainder, 0);
        chk("rst_dbz",       div_by_zero, 0);
        chk("rst_state",     32'(dbg_state), 32'(IDLE));

`ifndef BINARY_DIV_SIGNED_EN
        check_vec("d200_7",  8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 8);
        check_vec("d255_1",  8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 8);
        check_vec("d255_255",8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 8);
        check_vec("d3_200",  8'd3,   8'd200, 8'd0,   8'd3, 1'b0, 8);
`else
        check_vec("sm7_2",   8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 8);
        check_vec("s7_m2",   8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 8);
        check_vec("sm128_m1",8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
        check_vec("d3_100",  8'd3,  8'd100, 8'd0, 8'd3,  1'b0, 8);
`endif
        // divide by zero: result directly after the accepting edge
        check_vec("d5_0",    8'd5,   8'd0,   8'd255, 8'd5, 1'b1, 0);
        check_vec("d0_9",    8'd0,   8'd9,   8'd0,   8'd0, 1'b0, 8);

        // back-pressure with in_valid asserted while busy
        exp_q.push_back(8'd33);
        exp_q.push_back(8'd1);
        dividend = 8'd100;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        dividend = 8'd9;
        divisor  = 8'd9;
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, 8);
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_q", quotient, eq);
            chk("bp_r", remainder, er);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("bp_no_second", seen, 0);
        chk("bp_idle_rdy", in_ready, 1);

        // reset in the middle of a division
`ifndef BINARY_DIV_SIGNED_EN
        dividend = 8'd200;
`else
        dividend = 8'd100;
`endif
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready",  in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_q",         quotient, 0);
        chk("mid_rst_r",         remainder, 0);
        chk("mid_rst_dbz",       div_by_zero, 0);
        check_vec("d50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 8);

        // random sweep against the division identity
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            run_op(a, b, q, r, z, lat);
`ifndef BINARY_DIV_SIGNED_EN
            chk("inv_eq", 32'(q) * 32'(b) + 32'(r), 32'(a));
            chk("inv_lt", 32'(r < b), 1);
`else
            sa = int'($signed(a));
            sb = int'($signed(b));
            eq = W'(sa / sb);
            er = W'(sa % sb);
            chk("sinv_q", q, eq);
            chk("sinv_r", r, er);
`endif
            chk("inv_dbz", z, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
